// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 pipeline definitions.
//   - icode constants, register IDs (RNONE, RSP)
//   - D and E pipeline-register layouts as packed structs, plus bit offsets
//   - NOP bundles loaded on reset / bubble
package y86_pkg;

  localparam int WORD  = 64;
  localparam int NREGS = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  // D bus bit offsets (145 bits)
  localparam int D_W         = 145;
  localparam int D_STAT      = 144;
  localparam int D_ICODE_LSB = 140;
  localparam int D_IFUN_LSB  = 136;
  localparam int D_RA_LSB    = 132;
  localparam int D_RB_LSB    = 128;
  localparam int D_VALC_LSB  = 64;
  localparam int D_VALP_LSB  = 0;

  // E bus bit offsets (217 bits)
  localparam int E_W         = 217;
  localparam int E_STAT      = 216;
  localparam int E_ICODE_LSB = 212;
  localparam int E_IFUN_LSB  = 208;
  localparam int E_VALC_LSB  = 144;
  localparam int E_VALA_LSB  = 80;
  localparam int E_VALB_LSB  = 16;
  localparam int E_DSTE_LSB  = 12;
  localparam int E_DSTM_LSB  = 8;
  localparam int E_SRCA_LSB  = 4;
  localparam int E_SRCB_LSB  = 0;

  typedef struct packed {
    logic        stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  typedef struct packed {
    logic        stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [3:0]  srca;
    logic [3:0]  srcb;
  } e_reg_t;

  localparam d_reg_t D_NOP = '{stat: 1'b1, icode: INOP, ifun: 4'h0,
                               ra: RNONE, rb: RNONE, valc: 64'h0, valp: 64'h0};

  localparam e_reg_t E_NOP = '{stat: 1'b1, icode: INOP, ifun: 4'h0,
                               valc: 64'h0, vala: 64'h0, valb: 64'h0,
                               dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE};

endpackage

// File: rtl/regfile_2w2r.sv
// regfile_2w2r: NREGS x WORD register file.
//   clk, rst         : clock, synchronous active-high reset (clears all regs)
//   rd_a_id/rd_a     : combinational read port A (ID >= NREGS reads 0)
//   rd_b_id/rd_b     : combinational read port B
//   wr_e_id/wr_e_val : synchronous write port E
//   wr_m_id/wr_m_val : synchronous write port M, wins over E on same ID
// IDs >= NREGS (i.e. RNONE) never match a register, so such writes drop.
module regfile_2w2r
  import y86_pkg::*;
#(
  parameter int WORD  = 64,
  parameter int NREGS = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      rd_a_id,
  output logic [WORD-1:0] rd_a,
  input  logic [3:0]      rd_b_id,
  output logic [WORD-1:0] rd_b,
  input  logic [3:0]      wr_e_id,
  input  logic [WORD-1:0] wr_e_val,
  input  logic [3:0]      wr_m_id,
  input  logic [WORD-1:0] wr_m_val
);

  logic [NREGS-1:0][WORD-1:0] regs;

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst)                  regs[g] <= '0;
      else if (wr_m_id == 4'(g)) regs[g] <= wr_m_val;
      else if (wr_e_id == 4'(g)) regs[g] <= wr_e_val;
    end
  end

  // No write-to-read bypass: decode's forwarding chain already covers W.
  assign rd_a = (rd_a_id < 4'(NREGS)) ? regs[rd_a_id] : '0;
  assign rd_b = (rd_b_id < 4'(NREGS)) ? regs[rd_b_id] : '0;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode stage.
//   clk, rst            : clock, synchronous active-high reset
//   f_D                 : 145-bit fetch bus captured into the D register
//   D_stall, D_bubble   : D register hold / NOP insert (stall wins)
//   E_bubble            : E register NOP insert
//   e_/M_/W_ dst & val  : forwarding sources; W_* also write the regfile
//   d_srcA, d_srcB      : combinational source IDs for the hazard unit
//   D_icode             : icode held in the D register
//   E                   : 217-bit registered bus to execute
module decode_stage
  import y86_pkg::*;
#(
  parameter int WORD  = 64,
  parameter int NREGS = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [D_W-1:0]   f_D,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  input  logic [3:0]       e_dstE,
  input  logic [WORD-1:0]  e_valE,
  input  logic [3:0]       M_dstE,
  input  logic [WORD-1:0]  M_valE,
  input  logic [3:0]       M_dstM,
  input  logic [WORD-1:0]  m_valM,
  input  logic [3:0]       W_dstE,
  input  logic [WORD-1:0]  W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [WORD-1:0]  W_valM,
  output logic [3:0]       d_srcA,
  output logic [3:0]       d_srcB,
  output logic [3:0]       D_icode,
  output logic [E_W-1:0]   E
);

  d_reg_t          d_q;
  e_reg_t          e_q, e_d;
  logic [3:0]      src_a, src_b, dst_e, dst_m;
  logic [WORD-1:0] rf_a, rf_b, val_a, val_b;

  // D pipeline register
  always_ff @(posedge clk) begin
    if (rst)           d_q <= D_NOP;
    else if (!D_stall) d_q <= D_bubble ? D_NOP : d_reg_t'(f_D);
  end

  // Register ID selection
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_q.icode)
      IRRMOVQ: begin src_a = d_q.ra; dst_e = d_q.rb; end  // cmov: execute squashes dstE
      IIRMOVQ: dst_e = d_q.rb;
      IRMMOVQ: begin src_a = d_q.ra; src_b = d_q.rb; end
      IMRMOVQ: begin src_b = d_q.rb; dst_m = d_q.ra; end
      IOPQ:    begin src_a = d_q.ra; src_b = d_q.rb; dst_e = d_q.rb; end
      ICALL:   begin src_b = RSP; dst_e = RSP; end
      IRET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      IPUSHQ:  begin src_a = d_q.ra; src_b = RSP; dst_e = RSP; end
      IPOPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = d_q.ra; end
      default: ;
    endcase
  end

  regfile_2w2r #(.WORD(WORD), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rd_a_id  (src_a),
    .rd_a     (rf_a),
    .rd_b_id  (src_b),
    .rd_b     (rf_b),
    .wr_e_id  (W_dstE),
    .wr_e_val (W_valE),
    .wr_m_id  (W_dstM),
    .wr_m_val (W_valM)
  );

  // Forwarding: youngest producer first; within M, the load result beats
  // valE, and within W, valM beats valE (matches regfile write priority).
  // RNONE never matches so an unused source always reads 0.
  function automatic logic [WORD-1:0] fwd(
    input logic [3:0]      src,
    input logic [WORD-1:0] rf,
    input logic [3:0]      e_d,  input logic [WORD-1:0] e_v,
    input logic [3:0]      mm_d, input logic [WORD-1:0] mm_v,
    input logic [3:0]      me_d, input logic [WORD-1:0] me_v,
    input logic [3:0]      wm_d, input logic [WORD-1:0] wm_v,
    input logic [3:0]      we_d, input logic [WORD-1:0] we_v
  );
    if (src == RNONE)     return rf;
    else if (src == e_d)  return e_v;
    else if (src == mm_d) return mm_v;
    else if (src == me_d) return me_v;
    else if (src == wm_d) return wm_v;
    else if (src == we_d) return we_v;
    else                  return rf;
  endfunction

  always_comb begin
    val_a = fwd(src_a, rf_a, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                W_dstM, W_valM, W_dstE, W_valE);
    // call/jXX carry the return/fall-through address down the valA lane
    if (d_q.icode == IJXX || d_q.icode == ICALL) val_a = d_q.valp;
    val_b = fwd(src_b, rf_b, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                W_dstM, W_valM, W_dstE, W_valE);
  end

  always_comb begin
    e_d       = E_NOP;
    e_d.stat  = d_q.stat;
    e_d.icode = d_q.icode;
    e_d.ifun  = d_q.ifun;
    e_d.valc  = d_q.valc;
    e_d.vala  = val_a;
    e_d.valb  = val_b;
    e_d.dste  = dst_e;
    e_d.dstm  = dst_m;
    e_d.srca  = src_a;
    e_d.srcb  = src_b;
  end

  // E pipeline register
  always_ff @(posedge clk) begin
    if (rst || E_bubble) e_q <= E_NOP;
    else                 e_q <= e_d;
  end

  assign d_srcA  = src_a;
  assign d_srcB  = src_b;
  assign D_icode = d_q.icode;
  assign E       = e_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam logic [3:0] F = 4'hF;

  logic         clk = 1'b0;
  logic         rst;
  logic [144:0] f_D;
  logic         D_stall, D_bubble, E_bubble;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]   d_srcA, d_srcB, D_icode;
  logic [216:0] E;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .f_D(f_D),
    .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .D_icode(D_icode), .E(E)
  );

  typedef struct {
    logic        stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [3:0]  e_d;  logic [63:0] e_v;
    logic [3:0]  mm_d; logic [63:0] mm_v;
    logic [3:0]  me_d; logic [63:0] me_v;
    logic [3:0]  wm_d; logic [63:0] wm_v;
    logic [3:0]  we_d; logic [63:0] we_v;
    logic [63:0] xa, xb;
    logic [3:0]  xde, xdm, xsa, xsb;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [216:0] mk_e(
    input logic stat, input logic [3:0] icode, input logic [3:0] ifun,
    input logic [63:0] valc, input logic [63:0] vala, input logic [63:0] valb,
    input logic [3:0] de, input logic [3:0] dm, input logic [3:0] sa, input logic [3:0] sb);
    return {stat, icode, ifun, valc, vala, valb, de, dm, sa, sb};
  endfunction

  function automatic logic [144:0] mk_d(
    input logic stat, input logic [3:0] icode, input logic [3:0] ifun,
    input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] valc, input logic [63:0] valp);
    return {stat, icode, ifun, ra, rb, valc, valp};
  endfunction

  logic [216:0] e_nop;

  task automatic chk(input string name, input logic [216:0] act, input logic [216:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    e_dstE = F; e_valE = '0; M_dstM = F; m_valM = '0; M_dstE = F; M_valE = '0;
    W_dstM = F; W_valM = '0; W_dstE = F; W_valE = '0;
  endtask

  initial begin
    e_nop = mk_e(1'b1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, F);

    //          st    ic    ifn   rA    rB    valC       valP      e_d e_v        M_dstM m_valM  M_dstE M_valE    W_dstM W_valM   W_dstE W_valE    xA         xB         dE    dM    sA    sB
    vecs[0]  = '{1'b1,4'h3,4'h0,F,   4'h3,64'h10,   64'hA,  F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,   4'h3,64'h10, 64'h0,  64'h0,  4'h3,F,   F,   F};
    vecs[1]  = '{1'b1,4'h2,4'h0,4'h3,4'h1,64'h0,    64'h2,  F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,     64'h10, 64'h0,  4'h1,F,   4'h3,F};
    vecs[2]  = '{1'b1,4'h6,4'h0,4'h2,4'h3,64'h0,    64'h2,  4'h2,64'hAA,4'h2,64'hBB,4'h2,64'hCC,4'h2,64'hDD,4'h2,64'hEE, 64'hAA, 64'h10, 4'h3,F,   4'h2,4'h3};
    vecs[3]  = '{1'b1,4'h6,4'h0,4'h2,4'h3,64'h0,    64'h2,  F,64'hAA,  4'h2,64'hBB,4'h2,64'hCC,4'h2,64'hDD,4'h2,64'hEE, 64'hBB, 64'h10, 4'h3,F,   4'h2,4'h3};
    vecs[4]  = '{1'b1,4'h6,4'h0,4'h2,4'h3,64'h0,    64'h2,  F,64'hAA,  F,64'hBB,   4'h2,64'hCC,4'h2,64'hDD,4'h2,64'hEE, 64'hCC, 64'h10, 4'h3,F,   4'h2,4'h3};
    vecs[5]  = '{1'b1,4'h6,4'h0,4'h2,4'h3,64'h0,    64'h2,  F,64'hAA,  F,64'hBB,   F,64'hCC,   4'h2,64'hDD,4'h2,64'hEE, 64'hDD, 64'h10, 4'h3,F,   4'h2,4'h3};
    vecs[6]  = '{1'b1,4'h6,4'h0,4'h2,4'h3,64'h0,    64'h2,  F,64'h0,   F,64'h0,   F,64'h0,   F,64'hDD,   4'h2,64'h77, 64'h77, 64'h10, 4'h3,F,   4'h2,4'h3};
    vecs[7]  = '{1'b1,4'h6,4'h0,4'h2,4'h3,64'h0,    64'h2,  F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,     64'h77, 64'h10, 4'h3,F,   4'h2,4'h3};
    vecs[8]  = '{1'b1,4'h6,4'h1,4'h2,4'h3,64'h0,    64'h2,  4'h3,64'h55,F,64'h0,  F,64'h0,   F,64'h0,   F,64'h0,     64'h77, 64'h55, 4'h3,F,   4'h2,4'h3};
    vecs[9]  = '{1'b1,4'h3,4'h0,F,   4'h6,64'h5,    64'hA,  F,64'h99,  F,64'h99,  F,64'h99,  F,64'h99,  F,64'h99,    64'h0,  64'h0,  4'h6,F,   F,   F};
    vecs[10] = '{1'b1,4'h8,4'h0,F,   F,   64'h100,  64'h20, F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,     64'h20, 64'h0,  4'h4,F,   F,   4'h4};
    vecs[11] = '{1'b1,4'h7,4'h1,F,   F,   64'h40,   64'h29, F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,     64'h29, 64'h0,  F,   F,   F,   F};
    vecs[12] = '{1'b1,4'hB,4'h0,4'h5,F,   64'h0,    64'h2,  F,64'h0,   F,64'h0,   4'h4,64'h200,F,64'h0,  F,64'h0,     64'h200,64'h200,4'h4,4'h5,4'h4,4'h4};
    vecs[13] = '{1'b0,4'hC,4'h0,4'h1,4'h2,64'h7,    64'h8,  F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,     64'h0,  64'h0,  F,   F,   F,   F};
    vecs[14] = '{1'b1,4'h2,4'h3,4'h3,4'h7,64'h0,    64'h2,  F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,     64'h10, 64'h0,  4'h7,F,   4'h3,F};
    vecs[15] = '{1'b1,4'h5,4'h0,4'h8,4'h2,64'h18,   64'hA,  F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,   F,64'h0,     64'h0,  64'h77, F,   4'h8,F,   4'h2};

    rst = 1'b1; D_stall = 1'b0; D_bubble = 1'b0; E_bubble = 1'b0;
    f_D = mk_d(1'b1, 4'h1, 4'h0, F, F, 64'h0, 64'h0);
    clr_fwd();
    tick(); tick();
    chk("reset_E", E, e_nop);
    chk("reset_D_icode", 217'(D_icode), 217'(4'h1));
    chk("reset_srcA", 217'(d_srcA), 217'(F));
    rst = 1'b0;

    // Vector table: load D, check IDs, apply forwarding, check E.
    for (int i = 0; i < 16; i++) begin
      f_D = mk_d(vecs[i].stat, vecs[i].icode, vecs[i].ifun, vecs[i].ra, vecs[i].rb,
                 vecs[i].valc, vecs[i].valp);
      tick();
      chk($sformatf("v%0d_srcA", i), 217'(d_srcA), 217'(vecs[i].xsa));
      chk($sformatf("v%0d_srcB", i), 217'(d_srcB), 217'(vecs[i].xsb));
      e_dstE = vecs[i].e_d;  e_valE = vecs[i].e_v;
      M_dstM = vecs[i].mm_d; m_valM = vecs[i].mm_v;
      M_dstE = vecs[i].me_d; M_valE = vecs[i].me_v;
      W_dstM = vecs[i].wm_d; W_valM = vecs[i].wm_v;
      W_dstE = vecs[i].we_d; W_valE = vecs[i].we_v;
      tick();
      chk($sformatf("v%0d_E", i), E,
          mk_e(vecs[i].stat, vecs[i].icode, vecs[i].ifun, vecs[i].valc, vecs[i].xa,
               vecs[i].xb, vecs[i].xde, vecs[i].xdm, vecs[i].xsa, vecs[i].xsb));
      clr_fwd();
    end

    // Load/use: stall D with E bubble, then re-decode with fresh forwarding.
    f_D = mk_d(1'b1, 4'h5, 4'h0, 4'h9, 4'h3, 64'h30, 64'h3A);
    tick();
    D_stall = 1'b1; E_bubble = 1'b1;
    f_D = mk_d(1'b1, 4'h3, 4'h0, F, 4'h6, 64'h7, 64'h44);
    tick();
    chk("stall_E_nop", E, e_nop);
    chk("stall_D_hold", 217'(D_icode), 217'(4'h5));
    D_stall = 1'b0; E_bubble = 1'b0;
    W_dstE = 4'h3; W_valE = 64'h33;
    tick();
    chk("redecode_E", E, mk_e(1'b1, 4'h5, 4'h0, 64'h30, 64'h0, 64'h33, F, 4'h9, F, 4'h3));
    chk("after_stall_D", 217'(D_icode), 217'(4'h3));
    clr_fwd();
    D_stall = 1'b1; D_bubble = 1'b1;
    f_D = mk_d(1'b1, 4'hB, 4'h0, 4'h1, F, 64'h0, 64'h2);
    tick();
    chk("stall_over_bubble", 217'(D_icode), 217'(4'h3));
    D_stall = 1'b0;
    tick();
    chk("D_bubble", 217'(D_icode), 217'(4'h1));
    D_bubble = 1'b0;

    // Write-port collision: M port wins.
    f_D = mk_d(1'b1, 4'h2, 4'h0, 4'h5, 4'h6, 64'h0, 64'h2);
    W_dstE = 4'h5; W_valE = 64'h1; W_dstM = 4'h5; W_valM = 64'h2;
    tick();
    clr_fwd();
    tick();
    chk("collision_E", E, mk_e(1'b1, 4'h2, 4'h0, 64'h0, 64'h2, 64'h0, 4'h6, F, 4'h5, F));

    // Mid-stream reset overrides stall and W writes.
    rst = 1'b1; D_stall = 1'b1; W_dstE = 4'h5; W_valE = 64'h9;
    tick();
    chk("midreset_E", E, e_nop);
    chk("midreset_D", 217'(D_icode), 217'(4'h1));
    rst = 1'b0; D_stall = 1'b0; clr_fwd();
    tick(); tick();
    chk("post_reset_read", E, mk_e(1'b1, 4'h2, 4'h0, 64'h0, 64'h0, 64'h0, 4'h6, F, 4'h5, F));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Y86-64 pipeline decode stage, directly downstream of fetch.
- Owns the D pipeline register, which captures fetch's 145-bit D bus, and the 15-entry register file.
- Selects srcA/srcB/dstE/dstM, reads operands with full forwarding from E/M/W, and registers the result into the 217-bit E pipeline bus for execute.
- Hazard control (stall/bubble) is driven externally.

Parameters:
WORD, 64, datapath width; only 64 supported
NREGS, 15, architectural registers %rax..%r14; ID 15 = RNONE

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; synchronous, active-high
f_D  in  145  fetch bus: [144] stat, [143:140] icode, [139:136] ifun, [135:132] rA, [131:128] rB, [127:64] valC, [63:0] valP
D_stall  in  1  hold D register
D_bubble  in  1  load NOP into D register
E_bubble  in  1  load NOP into E register
e_dstE  in  4  execute-stage destination
e_valE  in  64  execute-stage ALU result
M_dstE  in  4  memory-stage dstE
M_valE  in  64  memory-stage valE
M_dstM  in  4  memory-stage dstM
m_valM  in  64  memory read data
W_dstE  in  4  writeback dstE; also register-file write port E
W_valE  in  64  writeback valE
W_dstM  in  4  writeback dstM; also register-file write port M
W_valM  in  64  writeback valM
d_srcA  out  4  combinational srcA, for hazard unit
d_srcB  out  4  combinational srcB, for hazard unit
D_icode  out  4  icode currently in D register, for ret detection
E  out  217  registered: [216] stat, [215:212] icode, [211:208] ifun, [207:144] valC, [143:80] valA, [79:16] valB, [15:12] dstE, [11:8] dstM, [7:4] srcA, [3:0] srcB

Behaviour:
- Reset (rst=1 at posedge):
  - D register = NOP: stat 1, icode 1, ifun 0, rA/rB 15, valC 0, valP 0.
  - E = NOP: stat 1, icode 1, ifun 0, vals 0, all reg IDs 15.
  - All 15 registers = 0.
  - Reset overrides stall/bubble and W writes.
- D register update (per posedge):
  - D_stall=1: hold.
  - D_stall=0, D_bubble=1: load NOP.
  - Otherwise: load f_D.
  - D_stall has priority over D_bubble.
- Source/destination selection (combinational, from D register):
  - srcA: rA for icode 2/4/6/A; RSP(4) for 9/B; else 15.
  - srcB: rB for icode 4/5/6; RSP for 8/9/A/B; else 15.
  - dstE: rB for icode 2/3/6; RSP for 8/9/A/B; else 15.
  - dstM: rA for icode 5/B; else 15.
  - cmovXX (icode 2, ifun!=0) keeps dstE=rB; execute squashes it.
- Register-file reads:
  - Combinational.
  - ID 15 reads 0.
- Register-file writes:
  - Two ports, at posedge, from W_dstE/W_valE and W_dstM/W_valM.
  - ID 15 ignored.
  - Same ID on both ports: W_valM wins.
  - No internal write-to-read bypass; the forwarding mux covers W.
- valA selection, first match wins:
  1. icode 7 or 8 -> valP.
  2. srcA==e_dstE -> e_valE.
  3. srcA==M_dstM -> m_valM.
  4. srcA==M_dstE -> M_valE.
  5. srcA==W_dstM -> W_valM.
  6. srcA==W_dstE -> W_valE.
  7. Otherwise -> rf[srcA].
  - No match is made when srcA==15.
- valB selection: same chain as valA starting at step 2, using srcB; no valP case.
- E register update (per posedge):
  - E_bubble=1: load NOP.
  - Otherwise: load {stat, icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB}.
  - Decode latency: one cycle from D register contents to E.
- Stall interaction: during D_stall with E_bubble, the same instruction is re-decoded next cycle with fresh forwarded values (load/use case).
- Invalid icode (>B): passes through; stat comes from fetch; all reg IDs 15.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT..IPOPQ).
  - RNONE=4'hF, RSP=4'h4.
  - NOP bundle constants for D and E.
  - D/E field bit-offset localparams.
- One sub-module: regfile_2w2r (15x64, two combinational read ports, two synchronous write ports, M-priority on collision, sync reset).

Test Plan:
- Reset, then f_D = irmovq $0x10,%rbx (icode 3, rA F, rB 3) -> one cycle later E: icode 3, valC 0x10, dstE 3, dstM F, srcA/srcB F.
- W_dstE=3, W_valE=0x10; next cycle decode rrmovq %rbx,%rcx (2,3,1) -> valA 0x10 from rf; dstE 1.
- Forwarding priority: srcA=2 with e_dstE=2/e_valE=0xAA, M_dstM=2/m_valM=0xBB -> valA=0xAA; drop e_dstE -> 0xBB; then M_valE, W_valM, W_valE in order.
- call at valP=0x20, valC=0x100 -> valA=0x20, srcB=4, dstE=4; jXX -> valA=valP, all dst F.
- D_stall=1 plus E_bubble=1 for one cycle -> E=NOP, D holds mrmovq; next cycle E carries mrmovq with dstM=rA. Also check D_stall+D_bubble together -> D holds.
- Same-cycle W_dstE=W_dstM=5 (0x1, 0x2) -> rf[5]=0x2. rst asserted mid-stream -> E=NOP and reads return 0 next cycle.
